// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and instruction-fetch sequencer. Holds the PC, presents it
// to instruction memory over a valid/ready handshake, and picks the next PC
// (PC+1 or a jump target) each time a fetch is accepted. A jump that arrives
// when no fetch is accepted is parked in a one-entry pending buffer and is
// applied at the next accept.
//
// Parameters
//   WIDTH       address width in bits
//   RESET_ADDR  PC value loaded on reset
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable
//   jmp_valid    in   single-cycle jump request strobe
//   jmp_addr     in   jump target (meaningful when jmp_valid=1)
//   fetch_valid  out  a fetch address is presented
//   fetch_addr   out  address being fetched (the current PC)
//   fetch_ready  in   memory accepts the fetch this cycle
//   jmp_pending  out  a buffered jump is waiting to be applied
//   busy         out  sequencer is in ISSUE
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             jmp_valid,
    input  logic [WIDTH-1:0] jmp_addr,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_addr,
    input  logic             fetch_ready,
    output logic             jmp_pending,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic             pend_q, pend_d;

    logic             accept;
    logic             jmp_taken;
    logic [WIDTH-1:0] jmp_tgt;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_sel;

    assign accept = (state_q == ISSUE) && fetch_ready;

    // A fresh jump in the accepting cycle outranks a buffered one.
    assign jmp_taken = jmp_valid || pend_q;
    assign jmp_tgt   = jmp_valid ? jmp_addr : pend_addr_q;
    assign pc_inc    = pc_q + WIDTH'(1);   // all-ones wraps to zero

    // Next-PC is a per-bit 2:1 select; sel = jump taken.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pc_mux
            assign pc_sel[gi] = jmp_taken ? jmp_tgt[gi] : pc_inc[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;

        case (state_q)
            IDLE: begin
                if (en) state_d = ISSUE;
            end
            ISSUE: begin
                // Without an accept the presented fetch is held, whatever en does.
                if (fetch_ready) begin
                    state_d = en ? ISSUE : IDLE;
                    pc_d    = pc_sel;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A jump that cannot be applied this cycle is buffered; newest wins.
        if (jmp_valid && !accept) begin
            pend_d      = 1'b1;
            pend_addr_d = jmp_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_ADDR;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign fetch_valid = (state_q == ISSUE);
    assign busy        = (state_q == ISSUE);
    assign fetch_addr  = pc_q;
    assign jmp_pending = pend_q;

endmodule
